// File: rtl/wb_ram_slave_pkg.sv
// Shared types and constants for the Wishbone RAM responder and the core
// that talks to it.
package wb_ram_slave_pkg;

    localparam int WB_DW      = 32;
    localparam int WB_SELW    = 4;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    // Opcodes the multicycle control FSM turns into bus cycles.
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/wb_ram_slave_if.sv
// Wishbone classic single-access bus between the core (master) and the RAM.
interface wb_ram_slave_if;
    import wb_ram_slave_pkg::*;

    // A request is valid while cyc & stb are high and is accepted on the
    // sampling edge while the responder is idle; it ends with exactly one
    // single-cycle ack or err pulse. Dropping cyc before that aborts it.
    logic               wb_cyc_i;
    logic               wb_stb_i;
    logic               wb_we_i;
    logic [31:0]        wb_addr_i;
    logic [WB_DW-1:0]   wb_dat_i;
    logic [WB_SELW-1:0] wb_sel_i;
    logic [WB_DW-1:0]   wb_dat_o;
    logic               wb_ack_o;
    logic               wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/wb_ram_array.sv
// Synchronous single-port RAM with byte-lane writes and a one-cycle,
// read-before-write registered read port.
module wb_ram_array
    import wb_ram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [WB_SELW-1:0]    sel,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WB_DW-1:0]      wdata,
    output logic [WB_DW-1:0]      rdata
);

    logic [WB_DW-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < WB_SELW; i++) begin
                if (we && sel[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM responder with programmable wait states, byte-lane
// writes, address-range decode and cyc-drop abort.
module wb_ram_slave
    import wb_ram_slave_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    wb_ram_slave_if.slave bus,
    output logic          busy_o,
    output wb_state_e     state_dbg
);

    localparam logic [WAIT_CNT_W-1:0] WS_LOAD =
        (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

    wb_state_e               state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    hit_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   word_q;
    logic [WB_DW-1:0]        dat_q;
    logic [WB_SELW-1:0]      sel_q;
    logic                    ack_q;
    logic                    err_q;
    logic                    rd_q;

    logic                    req;
    logic                    live_hit;
    logic                    use_live;
    logic                    cur_hit;
    logic                    cur_we;
    logic [ADDR_WIDTH-1:0]   cur_word;
    logic [WB_DW-1:0]        cur_dat;
    logic [WB_SELW-1:0]      cur_sel;
    logic                    go_resp;
    logic                    ram_en;
    logic [WB_DW-1:0]        ram_rdata;

    assign req      = bus.wb_cyc_i && bus.wb_stb_i;
    assign live_hit = (bus.wb_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2])
                      && (bus.wb_addr_i[1:0] == 2'b00);

    // With zero wait states the RAM is accessed on the sample edge itself,
    // so it must see the live bus rather than the latched request.
    assign use_live = (state == ST_IDLE);
    assign cur_hit  = use_live ? live_hit : hit_q;
    assign cur_we   = use_live ? bus.wb_we_i : we_q;
    assign cur_word = use_live ? bus.wb_addr_i[ADDR_WIDTH+1:2] : word_q;
    assign cur_dat  = use_live ? bus.wb_dat_i : dat_q;
    assign cur_sel  = use_live ? bus.wb_sel_i : sel_q;

    assign go_resp = ((state == ST_IDLE) && req && (WAIT_STATES == 0))
                     || ((state == ST_WAIT) && bus.wb_cyc_i && (wait_cnt == '0));
    assign ram_en  = go_resp && cur_hit && !wb_rst;

    wb_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (wb_clk),
        .en    (ram_en),
        .we    (cur_we),
        .sel   (cur_sel),
        .addr  (cur_word),
        .wdata (cur_dat),
        .rdata (ram_rdata)
    );

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            hit_q    <= 1'b0;
            we_q     <= 1'b0;
            word_q   <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        hit_q  <= live_hit;
                        we_q   <= bus.wb_we_i;
                        word_q <= bus.wb_addr_i[ADDR_WIDTH+1:2];
                        dat_q  <= bus.wb_dat_i;
                        sel_q  <= bus.wb_sel_i;
                        if (WAIT_STATES == 0) begin
                            state <= ST_RESP;
                            ack_q <= live_hit;
                            err_q <= !live_hit;
                            rd_q  <= live_hit && !bus.wb_we_i;
                        end else begin
                            wait_cnt <= WS_LOAD;
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!bus.wb_cyc_i) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == '0) begin
                        state <= ST_RESP;
                        ack_q <= hit_q;
                        err_q <= !hit_q;
                        rd_q  <= hit_q && !we_q;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    rd_q  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    rd_q  <= 1'b0;
                end
            endcase
        end
    end

    // Read data is only driven during a read ack, so misses and writes show 0.
    assign bus.wb_dat_o = rd_q ? ram_rdata : '0;
    assign bus.wb_ack_o = ack_q;
    assign bus.wb_err_o = err_q;
    assign busy_o       = (state != ST_IDLE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: three instances (0, 1 and 3 wait states) share one
// driver; a bench-side memory model feeds an expected-response queue.
module tb_wb_ram_slave;
    import wb_ram_slave_pkg::*;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic        cyc, stb, we;
    logic [31:0] addr, dat;
    logic [3:0]  sel;
    int          dsel;

    logic        ack, err, busy;
    logic [31:0] rdat;
    wb_state_e   st;
    logic        busy0, busy1, busy3;
    wb_state_e   st0, st1, st3;

    int n_checks = 0;
    int n_pass   = 0;

    logic [34:0] exp_q[$];
    logic [31:0] model [3][1024];

    wb_ram_slave_if b0();
    wb_ram_slave_if b1();
    wb_ram_slave_if b3();

    assign b0.wb_cyc_i = (dsel == 0) && cyc;
    assign b0.wb_stb_i = (dsel == 0) && stb;
    assign b0.wb_we_i = we;
    assign b0.wb_addr_i = addr;
    assign b0.wb_dat_i = dat;
    assign b0.wb_sel_i = sel;
    assign b1.wb_cyc_i = (dsel == 1) && cyc;
    assign b1.wb_stb_i = (dsel == 1) && stb;
    assign b1.wb_we_i = we;
    assign b1.wb_addr_i = addr;
    assign b1.wb_dat_i = dat;
    assign b1.wb_sel_i = sel;
    assign b3.wb_cyc_i = (dsel == 3) && cyc;
    assign b3.wb_stb_i = (dsel == 3) && stb;
    assign b3.wb_we_i = we;
    assign b3.wb_addr_i = addr;
    assign b3.wb_dat_i = dat;
    assign b3.wb_sel_i = sel;

    wb_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .bus(b0), .busy_o(busy0), .state_dbg(st0));
    wb_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_ws1 (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .bus(b1), .busy_o(busy1), .state_dbg(st1));
    wb_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .bus(b3), .busy_o(busy3), .state_dbg(st3));

    always_comb begin
        ack  = b1.wb_ack_o;
        err  = b1.wb_err_o;
        rdat = b1.wb_dat_o;
        busy = busy1;
        st   = st1;
        if (dsel == 0) begin
            ack  = b0.wb_ack_o;
            err  = b0.wb_err_o;
            rdat = b0.wb_dat_o;
            busy = busy0;
            st   = st0;
        end else if (dsel == 3) begin
            ack  = b3.wb_ack_o;
            err  = b3.wb_err_o;
            rdat = b3.wb_dat_o;
            busy = busy3;
            st   = st3;
        end
    end

    // ---------------- clock / reset ----------------
    always #5 wb_clk = ~wb_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge wb_clk) begin
        if (!wb_rst && (ack || err)) begin
            check("ack_err_excl", 32'(ack && err), 32'd0);
            check("resp_busy", 32'(busy), 32'd1);
        end
    end

    // ---------------- driver ----------------
    // Called at a falling edge with the selected responder idle (or in its
    // response cycle when the previous call held the strobe).
    task automatic bus_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int exp_lat, input logic hold,
                              output logic [31:0] rd);
        logic        hit;
        logic [34:0] e;
        logic [31:0] cur;
        int          n;
        int          m;
        m   = (dsel == 3) ? 2 : dsel;
        hit = (a[31:12] == 20'h0) && (a[1:0] == 2'b00);
        cur = model[m][a[11:2]];
        e[34]   = !w || !hit;
        e[33]   = !hit;
        e[32]   = hit;
        e[31:0] = (hit && !w) ? cur : 32'h0;
        exp_q.push_back(e);
        if (hit && w) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) model[m][a[11:2]][8*i +: 8] = d[8*i +: 8];
            end
        end
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; dat = d; sel = s;
        n = 0;
        do begin
            @(posedge wb_clk);
            n++;
            @(negedge wb_clk);
        end while (!(ack || err) && n < 40);
        check("latency", 32'(n), 32'(exp_lat));
        e = exp_q.pop_front();
        check("ack", 32'(ack), 32'(e[32]));
        check("err", 32'(err), 32'(e[33]));
        if (e[34]) check("rdata", rdat, e[31:0]);
        rd = rdat;
        if (!hold) begin
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
            @(negedge wb_clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          d_list[3];

        wb_rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; dat = '0; sel = '0;
        dsel = 1;
        d_list[0] = 0; d_list[1] = 1; d_list[2] = 3;
        repeat (3) @(negedge wb_clk);
        foreach (d_list[k]) begin
            dsel = d_list[k];
            #1;
            check("rst_ack", 32'(ack), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_dat", rdat, 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        dsel = 1;
        @(negedge wb_clk);
        wb_rst = 1'b0;
        @(negedge wb_clk);

        // Basic write/read, one wait state
        bus_access(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2, 1'b0, rd);
        bus_access(1'b0, 32'h10, 32'h0, 4'hF, 2, 1'b0, rd);
        check("basic_read", rd, 32'hDEAD_BEEF);

        // Byte lanes
        bus_access(1'b1, 32'h20, 32'h1122_3344, 4'hF, 2, 1'b0, rd);
        bus_access(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 2, 1'b0, rd);
        bus_access(1'b0, 32'h20, 32'h0, 4'h0, 2, 1'b0, rd);
        check("lane_read", rd, 32'h11BB_33DD);

        // Out of range and misaligned
        bus_access(1'b1, 32'h0, 32'h0123_4567, 4'hF, 2, 1'b0, rd);
        bus_access(1'b0, 32'h0000_1000, 32'h0, 4'hF, 2, 1'b0, rd);
        bus_access(1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 4'hF, 2, 1'b0, rd);
        bus_access(1'b0, 32'h0, 32'h0, 4'hF, 2, 1'b0, rd);
        check("misaligned_mem", rd, 32'h0123_4567);

        // Write with no lanes enabled
        bus_access(1'b1, 32'h30, 32'hCAFE_BABE, 4'hF, 2, 1'b0, rd);
        bus_access(1'b1, 32'h30, 32'h0000_0000, 4'h0, 2, 1'b0, rd);
        bus_access(1'b0, 32'h30, 32'h0, 4'hF, 2, 1'b0, rd);
        check("sel0_mem", rd, 32'hCAFE_BABE);

        // Random mix over a pre-initialised window
        for (int w = 16; w < 32; w++) begin
            bus_access(1'b1, 32'(w * 4), $urandom, 4'hF, 2, 1'b0, rd);
        end
        for (int i = 0; i < 12; i++) begin
            a = 32'($urandom_range(16, 31) * 4);
            case ($urandom_range(0, 2))
                0: bus_access(1'b0, a, 32'h0, 4'($urandom_range(0, 15)), 2, 1'b0, rd);
                1: bus_access(1'b1, a, $urandom, 4'($urandom_range(0, 15)), 2, 1'b0, rd);
                default: bus_access(1'b1, a + 32'($urandom_range(1, 3)), $urandom, 4'hF, 2, 1'b0, rd);
            endcase
        end

        // Abort with three wait states
        dsel = 3;
        bus_access(1'b1, 32'h8, 32'h1234_5678, 4'hF, 4, 1'b0, rd);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h8; dat = 32'h5555_5555; sel = 4'hF;
        @(posedge wb_clk);
        @(negedge wb_clk);
        check("abort_busy_wait", 32'(busy), 32'd1);
        cyc = 1'b0; stb = 1'b0;
        @(posedge wb_clk);
        @(negedge wb_clk);
        check("abort_busy_idle", 32'(busy), 32'd0);
        check("abort_state", 32'(st), 32'(ST_IDLE));
        for (int i = 0; i < 4; i++) begin
            check("abort_quiet", 32'(ack || err), 32'd0);
            @(negedge wb_clk);
        end
        we = 1'b0;
        bus_access(1'b0, 32'h8, 32'h0, 4'hF, 4, 1'b0, rd);
        check("abort_mem", rd, 32'h1234_5678);

        // Reset in the middle of a waiting write
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h8; dat = 32'hFFFF_0000; sel = 4'hF;
        @(posedge wb_clk);
        @(negedge wb_clk);
        @(posedge wb_clk);
        @(negedge wb_clk);
        check("rst_wait_busy_before", 32'(busy), 32'd1);
        wb_rst = 1'b1;
        #1;
        check("rst_wait_busy", 32'(busy), 32'd0);
        check("rst_wait_ack", 32'(ack), 32'd0);
        check("rst_wait_err", 32'(err), 32'd0);
        check("rst_wait_state", 32'(st), 32'(ST_IDLE));
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge wb_clk);
        wb_rst = 1'b0;
        @(negedge wb_clk);
        bus_access(1'b0, 32'h8, 32'h0, 4'hF, 4, 1'b0, rd);
        check("rst_wait_mem", rd, 32'h1234_5678);

        // Zero wait states, back-to-back reads with the strobe held
        dsel = 0;
        bus_access(1'b1, 32'h0, 32'hA0A0_A0A0, 4'hF, 1, 1'b0, rd);
        bus_access(1'b1, 32'h4, 32'hB1B1_B1B1, 4'hF, 1, 1'b0, rd);
        bus_access(1'b0, 32'h0, 32'h0, 4'hF, 1, 1'b1, rd);
        check("b2b_read0", rd, 32'hA0A0_A0A0);
        bus_access(1'b0, 32'h4, 32'h0, 4'hF, 2, 1'b0, rd);
        check("b2b_read1", rd, 32'hB1B1_B1B1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
